// File: rtl/lsp_prev_compose_update.sv
// lsp_prev_compose_update: MA-predicted LSP compose followed by freq_prev history shift
module lsp_prev_compose_update (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [11:0] lspele,
  input  logic [11:0] freq_prev,
  input  logic [11:0] lsp,
  input  logic [11:0] fgAddr,
  input  logic [11:0] fg_sumAddr,
  output logic [11:0] readAddr,
  input  logic [31:0] readIn,
  output logic [11:0] writeAddr,
  output logic [31:0] writeOut,
  output logic        writeEn,
  output logic [11:0] constantMemAddr,
  input  logic [31:0] constantMemIn
);
  typedef enum logic [2:0] {IDLE, C_LOAD, C_MULT, C_MAC, C_WRITE, U_READ, U_WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] j_q, j_d;
  logic [1:0] k_q, k_d, kn, km;
  logic [31:0] acc_q, acc_d, prod, mac;
  logic j_last;
  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return (a == 16'h8000 && b == 16'h8000) ? 32'h7fff_ffff : {p[30:0], 1'b0};
  endfunction
  function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    return (s[32] == s[31]) ? s[31:0] : {s[32], {31{~s[32]}}};
  endfunction
  assign prod = l_mult(readIn[15:0], constantMemIn[15:0]);
  assign mac = l_add(acc_q, prod);
  assign j_last = j_q == 4'd9;
  assign kn = k_q + 2'd1;
  assign km = k_q - 2'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q <= '0;
      k_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      j_q <= j_d;
      k_q <= k_d;
      acc_q <= acc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    j_d = j_q;
    k_d = k_q;
    acc_d = acc_q;
    done = 1'b0;
    readAddr = '0;
    writeAddr = '0;
    writeOut = '0;
    writeEn = 1'b0;
    constantMemAddr = '0;
    case (state_q)
      IDLE: begin
        state_d = start ? C_LOAD : IDLE;
        j_d = start ? 4'd0 : j_q;
      end
      C_LOAD: begin
        readAddr = {lspele[11:4], j_q};
        constantMemAddr = {fg_sumAddr[11:4], j_q};
        state_d = C_MULT;
      end
      C_MULT: begin
        acc_d = prod;
        readAddr = {freq_prev[11:6], 2'd0, j_q};
        constantMemAddr = {fgAddr[11:6], 2'd0, j_q};
        k_d = 2'd0;
        state_d = C_MAC;
      end
      C_MAC: begin
        acc_d = mac;
        if (k_q != 2'd3) begin
          readAddr = {freq_prev[11:6], kn, j_q};
          constantMemAddr = {fgAddr[11:6], kn, j_q};
          k_d = kn;
        end else begin
          state_d = C_WRITE;
        end
      end
      C_WRITE: begin
        writeEn = 1'b1;
        writeAddr = {lsp[11:4], j_q};
        writeOut = {{16{acc_q[31]}}, acc_q[31:16]};
        j_d = j_last ? 4'd0 : j_q + 4'd1;
        k_d = j_last ? 2'd3 : k_q;
        state_d = j_last ? U_READ : C_LOAD;
      end
      U_READ: begin
        readAddr = (k_q == 2'd0) ? {lspele[11:4], j_q} : {freq_prev[11:6], km, j_q};
        state_d = U_WRITE;
      end
      U_WRITE: begin
        writeEn = 1'b1;
        writeAddr = {freq_prev[11:6], k_q, j_q};
        writeOut = readIn;
        j_d = j_last ? 4'd0 : j_q + 4'd1;
        k_d = (j_last && k_q != 2'd0) ? km : k_q;
        state_d = (j_last && k_q == 2'd0) ? DONE : U_READ;
      end
      DONE: begin
        done = 1'b1;
        j_d = '0;
        k_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsp_prev_compose_update.sv
// tb_lsp_prev_compose_update: randomized and directed checks against an arithmetic reference model
module tb_lsp_prev_compose_update;
  localparam int LE = 'h100, FP = 'h200, LS = 'h300, FG = 'h040, FS = 'h080;
  localparam longint MAXV = 64'sd2147483647, MINV = -64'sd2147483648;
  logic clk = 0, reset = 1, start = 0;
  logic done, writeEn;
  logic [11:0] readAddr, writeAddr, constantMemAddr;
  logic [31:0] readIn, writeOut, constantMemIn;
  logic [31:0] mem [4096];
  logic [31:0] cmem [4096];
  logic [31:0] exp_lsp [10];
  logic [31:0] exp_fp [4][10];
  int cmp = 0, err = 0;

  lsp_prev_compose_update dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .lspele(12'h10A), .freq_prev(12'h23F), .lsp(12'h309),
    .fgAddr(12'h07C), .fg_sumAddr(12'h08B),
    .readAddr(readAddr), .readIn(readIn),
    .writeAddr(writeAddr), .writeOut(writeOut), .writeEn(writeEn),
    .constantMemAddr(constantMemAddr), .constantMemIn(constantMemIn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (writeEn) mem[writeAddr] <= writeOut;
    readIn <= mem[readAddr];
    constantMemIn <= cmem[constantMemAddr];
  end

  function automatic int s16(input logic [31:0] w);
    logic signed [15:0] h;
    h = w[15:0];
    return int'(h);
  endfunction

  function automatic longint lm(input int a, input int b);
    if (a == -32768 && b == -32768) return MAXV;
    return longint'(a) * longint'(b) * 2;
  endfunction

  function automatic longint sat(input longint v);
    return v > MAXV ? MAXV : (v < MINV ? MINV : v);
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] r;
    logic [15:0] lo;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: lo = 16'h8000;
      1: lo = 16'h7fff;
      2: lo = 16'h0000;
      default: lo = r[15:0];
    endcase
    r = $urandom;
    return {r[31:16], lo};
  endfunction

  task automatic model();
    longint acc;
    for (int j = 0; j < 10; j++) begin
      acc = lm(s16(mem[LE + j]), s16(cmem[FS + j]));
      for (int k = 0; k < 4; k++)
        acc = sat(acc + lm(s16(mem[FP + 16 * k + j]), s16(cmem[FG + 16 * k + j])));
      exp_lsp[j] = int'(acc >>> 16);
      exp_fp[0][j] = mem[LE + j];
      for (int k = 1; k < 4; k++) exp_fp[k][j] = mem[FP + 16 * (k - 1) + j];
    end
  endtask

  task automatic fill_random(input bit hist);
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = pick();
      cmem[FS + j] = pick();
      for (int k = 0; k < 4; k++) begin
        cmem[FG + 16 * k + j] = pick();
        if (hist) mem[FP + 16 * k + j] = pick();
      end
    end
  endtask

  task automatic run_pass(input int p1, input int p2, output int cyc, output int wr, output logic dbl);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    cyc = 1;
    wr = int'(writeEn);
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1 || cyc == p2);
      wr += int'(writeEn);
    end
    start = 0;
    @(negedge clk) dbl = done;
  endtask

  task automatic test_reset();
    #1;
    cmp++;
    if ({done, writeEn, writeOut, writeAddr, readAddr, constantMemAddr} !== '0) begin
      err++; $display("FAIL reset_outputs got %b exp 0", {done, writeEn, writeOut, writeAddr, readAddr, constantMemAddr});
    end
    @(negedge clk) reset = 0;
    repeat (3) @(negedge clk);
    cmp++;
    if ({done, writeEn, readAddr, constantMemAddr} !== '0) begin
      err++; $display("FAIL idle_outputs got %b exp 0", {done, writeEn, readAddr, constantMemAddr});
    end
  endtask

  task automatic test_zero_history();
    int cyc, wr;
    logic dbl;
    fill_random(0);
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = 32'h2000;
      cmem[FS + j] = 32'h4000;
      for (int k = 0; k < 4; k++) mem[FP + 16 * k + j] = 0;
    end
    run_pass(0, 0, cyc, wr, dbl);
    cmp++; if (cyc != 151) begin err++; $display("FAIL zero_done_cycle got %0d exp 151", cyc); end
    cmp++; if (wr != 50) begin err++; $display("FAIL zero_writes got %0d exp 50", wr); end
    cmp++; if (dbl !== 1'b0) begin err++; $display("FAIL zero_done_width got %b exp 0", dbl); end
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== 32'h1000) begin err++; $display("FAIL zero_lsp[%0d] got %h exp 00001000", j, mem[LS + j]); end
      cmp++; if (mem[FP + j] !== 32'h2000) begin err++; $display("FAIL zero_fp0[%0d] got %h exp 00002000", j, mem[FP + j]); end
      for (int k = 1; k < 4; k++) begin
        cmp++; if (mem[FP + 16 * k + j] !== 0) begin err++; $display("FAIL zero_fp%0d[%0d] got %h exp 0", k, j, mem[FP + 16 * k + j]); end
      end
    end
  endtask

  task automatic test_negative();
    int cyc, wr;
    logic dbl;
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = 32'habcd_c000;
      cmem[FS + j] = 32'h5555_4000;
      for (int k = 0; k < 4; k++) mem[FP + 16 * k + j] = 0;
    end
    run_pass(0, 0, cyc, wr, dbl);
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== 32'hffff_e000) begin err++; $display("FAIL neg_lsp[%0d] got %h exp ffffe000", j, mem[LS + j]); end
      cmp++; if (mem[FP + j] !== 32'habcd_c000) begin err++; $display("FAIL neg_fp0[%0d] got %h exp abcdc000", j, mem[FP + j]); end
    end
  endtask

  task automatic test_saturation();
    int cyc, wr;
    logic dbl;
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = 32'h8000;
      cmem[FS + j] = 32'h8000;
      for (int k = 0; k < 4; k++) begin
        mem[FP + 16 * k + j] = 32'h7fff;
        cmem[FG + 16 * k + j] = 32'h7fff;
      end
    end
    run_pass(0, 0, cyc, wr, dbl);
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== 32'h7fff) begin err++; $display("FAIL satpos_lsp[%0d] got %h exp 00007fff", j, mem[LS + j]); end
    end
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = 32'h8000;
      cmem[FS + j] = 32'h7fff;
      for (int k = 0; k < 4; k++) mem[FP + 16 * k + j] = 32'h8000;
    end
    run_pass(0, 0, cyc, wr, dbl);
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== 32'hffff_8000) begin err++; $display("FAIL satneg_lsp[%0d] got %h exp ffff8000", j, mem[LS + j]); end
    end
  endtask

  task automatic test_history_shift();
    int cyc, wr;
    logic dbl;
    fill_random(0);
    for (int j = 0; j < 10; j++) begin
      mem[LE + j] = 32'h0a00 + j;
      for (int k = 0; k < 4; k++) mem[FP + 16 * k + j] = 32'h100 * k + j;
    end
    model();
    run_pass(0, 0, cyc, wr, dbl);
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL shift_lsp[%0d] got %h exp %h", j, mem[LS + j], exp_lsp[j]); end
      for (int k = 0; k < 4; k++) begin
        cmp++;
        if (mem[FP + 16 * k + j] !== (k == 0 ? 32'h0a00 + j : 32'h100 * (k - 1) + j)) begin
          err++; $display("FAIL shift_fp%0d[%0d] got %h exp %h", k, j, mem[FP + 16 * k + j], k == 0 ? 32'h0a00 + j : 32'h100 * (k - 1) + j);
        end
      end
    end
  endtask

  task automatic test_random();
    int cyc, wr;
    logic dbl;
    for (int p = 0; p < 4; p++) begin
      fill_random(p == 0);
      model();
      run_pass(0, 0, cyc, wr, dbl);
      cmp++; if (cyc != 151 || wr != 50) begin err++; $display("FAIL rand%0d_timing got cyc=%0d wr=%0d exp 151/50", p, cyc, wr); end
      for (int j = 0; j < 10; j++) begin
        cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL rand%0d_lsp[%0d] got %h exp %h", p, j, mem[LS + j], exp_lsp[j]); end
        for (int k = 0; k < 4; k++) begin
          cmp++; if (mem[FP + 16 * k + j] !== exp_fp[k][j]) begin err++; $display("FAIL rand%0d_fp%0d[%0d] got %h exp %h", p, k, j, mem[FP + 16 * k + j], exp_fp[k][j]); end
        end
      end
    end
  endtask

  task automatic test_handshake();
    int cyc, wr, bad;
    logic dbl;
    fill_random(1);
    model();
    run_pass(10, 100, cyc, wr, dbl);
    cmp++; if (cyc != 151) begin err++; $display("FAIL hs_done_cycle got %0d exp 151", cyc); end
    cmp++; if (wr != 50) begin err++; $display("FAIL hs_writes got %0d exp 50", wr); end
    cmp++; if (dbl !== 1'b0) begin err++; $display("FAIL hs_done_width got %b exp 0", dbl); end
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL hs_lsp[%0d] got %h exp %h", j, mem[LS + j], exp_lsp[j]); end
      cmp++; if (mem[FP + 48 + j] !== exp_fp[3][j]) begin err++; $display("FAIL hs_fp3[%0d] got %h exp %h", j, mem[FP + 48 + j], exp_fp[3][j]); end
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad += int'(writeEn || done || readAddr != 0);
    end
    cmp++; if (bad != 0) begin err++; $display("FAIL hs_stays_idle got %0d busy cycles exp 0", bad); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    fill_random(1);
    model();
    @(negedge clk) start = 1;
    cyc = 0;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    cmp++; if (cyc != 151) begin err++; $display("FAIL b2b_first_cycle got %0d exp 151", cyc); end
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL b2b1_lsp[%0d] got %h exp %h", j, mem[LS + j], exp_lsp[j]); end
    end
    model();
    @(negedge clk);
    cmp++; if (readAddr !== 12'h000 || done !== 1'b0) begin err++; $display("FAIL b2b_idle got addr=%h done=%b exp 000/0", readAddr, done); end
    @(negedge clk);
    cmp++; if (readAddr !== 12'h100) begin err++; $display("FAIL b2b_restart got %h exp 100", readAddr); end
    start = 0;
    cyc = 1;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    cmp++; if (cyc != 151) begin err++; $display("FAIL b2b_second_cycle got %0d exp 151", cyc); end
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL b2b2_lsp[%0d] got %h exp %h", j, mem[LS + j], exp_lsp[j]); end
      cmp++; if (mem[FP + 16 + j] !== exp_fp[1][j]) begin err++; $display("FAIL b2b2_fp1[%0d] got %h exp %h", j, mem[FP + 16 + j], exp_fp[1][j]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midpass();
    int cyc, wr, bad;
    logic dbl;
    logic [31:0] snap [64];
    fill_random(1);
    for (int i = 0; i < 64; i++) snap[i] = mem[FP + i];
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (39) @(negedge clk);
    reset = 1;
    #1;
    cmp++;
    if ({done, writeEn, writeOut, writeAddr, readAddr, constantMemAddr} !== '0) begin
      err++; $display("FAIL midreset_outputs got %b exp 0", {done, writeEn, writeOut, writeAddr, readAddr, constantMemAddr});
    end
    bad = 0;
    repeat (3) begin @(negedge clk); bad += int'(writeEn || done); end
    reset = 0;
    repeat (8) begin @(negedge clk); bad += int'(writeEn || done); end
    cmp++; if (bad != 0) begin err++; $display("FAIL midreset_quiet got %0d active cycles exp 0", bad); end
    bad = 0;
    for (int i = 0; i < 64; i++) bad += int'(mem[FP + i] !== snap[i]);
    cmp++; if (bad != 0) begin err++; $display("FAIL midreset_history got %0d changed words exp 0", bad); end
    model();
    run_pass(0, 0, cyc, wr, dbl);
    cmp++; if (cyc != 151 || wr != 50) begin err++; $display("FAIL midreset_rerun got cyc=%0d wr=%0d exp 151/50", cyc, wr); end
    for (int j = 0; j < 10; j++) begin
      cmp++; if (mem[LS + j] !== exp_lsp[j]) begin err++; $display("FAIL midreset_lsp[%0d] got %h exp %h", j, mem[LS + j], exp_lsp[j]); end
      for (int k = 0; k < 4; k++) begin
        cmp++; if (mem[FP + 16 * k + j] !== exp_fp[k][j]) begin err++; $display("FAIL midreset_fp%0d[%0d] got %h exp %h", k, j, mem[FP + 16 * k + j], exp_fp[k][j]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 0;
      cmem[i] = 0;
    end
    test_reset();
    test_zero_history();
    test_negative();
    test_saturation();
    test_history_shift();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_midpass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
